// File: rtl/mem_responder.sv
// Memory-side responder for the core's doubleword interface: two registered read
// ports, one write port, write-first collisions, post-reset zeroing sweep.
module mem_responder #(
  parameter int ADDR_BITS  = 61,
  parameter int DEPTH_LOG2 = 14,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 readEn0,
  input  logic [0:ADDR_BITS-1] readAddr0,
  output logic [0:63]          readData0,
  input  logic                 readEn1,
  input  logic [0:ADDR_BITS-1] readAddr1,
  output logic [0:63]          readData1,
  input  logic                 writeEn,
  input  logic [0:ADDR_BITS-1] writeAddr,
  input  logic [0:63]          writeData,
  output logic                 busy,
  output logic                 addrErr
);
  localparam int DATA_BITS = 64;
  localparam int DEPTH     = 1 << DEPTH_LOG2;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

  logic [0:DATA_BITS-1]  mem [DEPTH];
  logic [0:0]            state_reg;
  logic [DEPTH_LOG2-1:0] cnt_reg;
  logic                  err_reg;
  logic                  ready;

  assign ready = (state_reg == ST_READY);

  // Index is the low DEPTH_LOG2 bits (highest-numbered in big-endian order);
  // every bit above them must be zero for the access to be in range.
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  wr_ok;
  logic                  wr_fire;
  logic                  wr_bad;

  assign wr_idx  = writeAddr[ADDR_BITS-DEPTH_LOG2 : ADDR_BITS-1];
  assign wr_ok   = (writeAddr[0 : ADDR_BITS-1-DEPTH_LOG2] == '0);
  assign wr_fire = ready && writeEn && wr_ok;
  assign wr_bad  = ready && writeEn && !wr_ok;

  logic                 rd_en   [2];
  logic [0:ADDR_BITS-1] rd_addr [2];
  logic [1:0]           rd_bad;

  assign rd_en[0]   = readEn0;
  assign rd_en[1]   = readEn1;
  assign rd_addr[0] = readAddr0;
  assign rd_addr[1] = readAddr1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [DEPTH_LOG2-1:0] idx;
      logic                  ok;
      logic [0:DATA_BITS-1]  data_reg;

      assign idx        = rd_addr[gi][ADDR_BITS-DEPTH_LOG2 : ADDR_BITS-1];
      assign ok         = (rd_addr[gi][0 : ADDR_BITS-1-DEPTH_LOG2] == '0);
      assign rd_bad[gi] = ready && rd_en[gi] && !ok;

      // Write-first: a same-cycle store to the same index bypasses the array.
      always_ff @(posedge clk) begin
        if (reset) begin
          data_reg <= '0;
        end else if (ready && rd_en[gi]) begin
          if (!ok) begin
            data_reg <= '0;
          end else if (wr_fire && (wr_idx == idx)) begin
            data_reg <= writeData;
          end else begin
            data_reg <= mem[idx];
          end
        end
      end
    end
  endgenerate

  assign readData0 = g_rd[0].data_reg;
  assign readData1 = g_rd[1].data_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= INIT_CLEAR ? ST_CLEAR : ST_READY;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else if (!ready) begin
      cnt_reg <= cnt_reg + 1'b1;
      if (cnt_reg == LAST_IDX) begin
        state_reg <= ST_READY;
      end
    end else if (wr_bad || (|rd_bad)) begin
      err_reg <= 1'b1;
    end
  end

  // Array has no reset; the sweep is the only thing that zeroes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!ready) begin
        mem[cnt_reg] <= '0;
      end else if (wr_fire) begin
        mem[wr_idx] <= writeData;
      end
    end
  end

  assign busy    = !ready;
  assign addrErr = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (DEPTH_LOG2=4, INIT_CLEAR=1) with a per-cycle
// reference model and literal spot checks.
module tb_mem_responder;
  localparam int DL2 = 4;
  localparam int NDW = 1 << DL2;

  logic        clk = 1'b0;
  logic        reset;
  logic        readEn0, readEn1, writeEn;
  logic [0:60] readAddr0, readAddr1, writeAddr;
  logic [0:63] writeData;
  logic [0:63] readData0, readData1;
  logic        busy, addrErr;

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  mem_responder #(.ADDR_BITS(61), .DEPTH_LOG2(DL2), .INIT_CLEAR(1'b1)) dut (
    .clk(clk), .reset(reset),
    .readEn0(readEn0), .readAddr0(readAddr0), .readData0(readData0),
    .readEn1(readEn1), .readAddr1(readAddr1), .readData1(readData1),
    .writeEn(writeEn), .writeAddr(writeAddr), .writeData(writeData),
    .busy(busy), .addrErr(addrErr)
  );

  always #5 clk = ~clk;

  // Reference model: whole-array semantics, sweep treated as an opaque delay.
  logic [63:0] m_mem [NDW];
  logic [63:0] m_rd0 = '0, m_rd1 = '0;
  logic        m_err = 1'b0;
  int          m_clear_left = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_rd0 = '0; m_rd1 = '0; m_err = 1'b0; m_clear_left = NDW;
    end else if (m_clear_left > 0) begin
      m_clear_left--;
      if (m_clear_left == 0)
        for (int i = 0; i < NDW; i++) m_mem[i] = '0;
    end else begin
      if (writeEn) begin
        if ((writeAddr >> DL2) == 0) m_mem[int'(writeAddr % NDW)] = writeData;
        else m_err = 1'b1;
      end
      if (readEn0) begin
        if ((readAddr0 >> DL2) == 0) m_rd0 = m_mem[int'(readAddr0 % NDW)];
        else begin m_rd0 = '0; m_err = 1'b1; end
      end
      if (readEn1) begin
        if ((readAddr1 >> DL2) == 0) m_rd1 = m_mem[int'(readAddr1 % NDW)];
        else begin m_rd1 = '0; m_err = 1'b1; end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("model_busy", {63'd0, busy}, {63'd0, m_clear_left > 0});
      chk("model_addrErr", {63'd0, addrErr}, {63'd0, m_err});
      chk("model_readData0", readData0, m_rd0);
      chk("model_readData1", readData1, m_rd1);
    end
  end

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    $display("txn %s act=%h exp=%h", name, act, exp);
    chk(name, act, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    readEn0 = 1'b0; readEn1 = 1'b0; writeEn = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      cyc();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1; idle();
    readAddr0 = '0; readAddr1 = '0; writeAddr = '0; writeData = '0;
    run = 1'b1;
    cyc();
    lit("reset_busy", {63'd0, busy}, 64'd1);
    lit("reset_rd0", readData0, 64'd0);
    reset = 1'b0;

    // Requests during the sweep must be ignored entirely.
    writeEn = 1'b1; writeAddr = 61'd2; writeData = 64'hAA;
    readEn0 = 1'b1; readAddr0 = 61'h10;
    count_busy(n);
    idle();
    lit("sweep_len", n, 64'd16);
    lit("no_err_in_clear", {63'd0, addrErr}, 64'd0);

    for (int i = 0; i < NDW; i++) begin
      readEn0 = 1'b1; readAddr0 = 61'(i);
      readEn1 = 1'b1; readAddr1 = 61'(NDW - 1 - i);
      cyc();
      chk("cleared_rd0", readData0, 64'd0);
    end
    idle();

    writeEn = 1'b1; writeAddr = 61'd5; writeData = 64'h0123456789ABCDEF;
    cyc(); idle();
    readEn1 = 1'b1; readAddr1 = 61'd5;
    cyc();
    lit("rd1_addr5", readData1, 64'h0123456789ABCDEF);
    readEn1 = 1'b0; readAddr1 = 61'd0;
    cyc(); cyc();
    lit("rd1_hold", readData1, 64'h0123456789ABCDEF);

    writeEn = 1'b1; writeAddr = 61'd3; writeData = 64'hFFFF0000FFFF0000;
    readEn0 = 1'b1; readAddr0 = 61'd3;
    readEn1 = 1'b1; readAddr1 = 61'd3;
    cyc(); idle();
    lit("collide_rd0", readData0, 64'hFFFF0000FFFF0000);
    lit("collide_rd1", readData1, 64'hFFFF0000FFFF0000);

    readEn0 = 1'b1; readAddr0 = 61'd5;
    readEn1 = 1'b1; readAddr1 = 61'd3;
    cyc(); idle();
    lit("dual_rd0", readData0, 64'h0123456789ABCDEF);
    lit("dual_rd1", readData1, 64'hFFFF0000FFFF0000);

    writeEn = 1'b1; writeAddr = 61'd0; writeData = 64'hDEADBEEFCAFEF00D;
    cyc(); idle();
    readEn0 = 1'b1; readAddr0 = 61'h10;
    cyc(); idle();
    lit("oor_rd0", readData0, 64'd0);
    lit("oor_err", {63'd0, addrErr}, 64'd1);
    writeEn = 1'b1; writeAddr = 61'h20; writeData = 64'h1111;
    cyc(); idle();
    readEn0 = 1'b1; readAddr0 = 61'd0;
    cyc(); idle();
    lit("idx0_untouched", readData0, 64'hDEADBEEFCAFEF00D);
    lit("err_sticky", {63'd0, addrErr}, 64'd1);
    readEn1 = 1'b1; readAddr1 = {1'b1, 60'd0};
    cyc(); idle();
    lit("msb_oor_rd1", readData1, 64'd0);

    writeEn = 1'b1; writeAddr = 61'd9; writeData = 64'h55;
    cyc(); idle();
    readEn0 = 1'b1; readAddr0 = 61'd9;
    cyc(); idle();
    lit("rd0_idx9", readData0, 64'h55);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    lit("ready_reset_rd0", readData0, 64'd0);
    lit("ready_reset_err", {63'd0, addrErr}, 64'd0);
    for (int i = 0; i < 7; i++) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    count_busy(n);
    lit("resweep_len", n, 64'd16);

    readEn0 = 1'b1; readAddr0 = 61'd9;
    readEn1 = 1'b1; readAddr1 = 61'd5;
    cyc(); idle();
    lit("post_sweep_idx9", readData0, 64'd0);
    lit("post_sweep_idx5", readData1, 64'd0);

    writeEn = 1'b1; writeAddr = 61'd15; writeData = 64'hA5A55A5A0F0FF0F0;
    readEn0 = 1'b1; readAddr0 = 61'd15;
    readEn1 = 1'b1; readAddr1 = 61'd14;
    cyc(); idle();
    lit("top_idx_bypass", readData0, 64'hA5A55A5A0F0FF0F0);
    lit("top_idx_neighbour", readData1, 64'd0);
    cyc();
    run = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side end of the core's doubleword memory interface: two read ports (fetch and load) and one write port (store).
- Addresses are 61-bit doubleword indices, i.e. the byte address with its low 3 bits dropped. Data is 64 bits, big-endian, with bit 0 as the MSB.
- Backed by a 2^DEPTH_LOG2-doubleword array. Reads have one-cycle registered latency.
- After reset, a clear sweep zeroes the array. Accesses to addresses outside the array are flagged.

Parameters:
- ADDR_BITS, 61, width of every address port; fixed by the core interface.
- DEPTH_LOG2, 14, log2 of backing array depth in doublewords.
- INIT_CLEAR, 1, when 1 a zeroing sweep runs after every reset; when 0 the block is ready immediately.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- readEn0  in  1  load read request.
- readAddr0  in  [0:60]  load doubleword address.
- readData0  out  [0:63]  load read data (registered).
- readEn1  in  1  fetch read request.
- readAddr1  in  [0:60]  fetch doubleword address.
- readData1  out  [0:63]  fetch read data (registered).
- writeEn  in  1  store request.
- writeAddr  in  [0:60]  store doubleword address.
- writeData  in  [0:63]  store data.
- busy  out  1  clear sweep in progress; port requests are ignored while high.
- addrErr  out  1  sticky flag: an out-of-range access was seen.

Behaviour:
- Clocking and reset: single clock, clk. Reset is synchronous, active-high, and named reset.
- Reset values:
  - readData0 = 0, readData1 = 0, addrErr = 0.
  - busy = INIT_CLEAR.
  - Clear counter = 0.
  - State = CLEAR if INIT_CLEAR, else READY.
  - Array contents are not touched by reset itself.
- Index and range:
  - idx = addr[61-DEPTH_LOG2:60], the low DEPTH_LOG2 bits.
  - An address is in range iff addr[0:60-DEPTH_LOG2] == 0.
- State machine, 2 states:
  - CLEAR:
    - Each cycle writes 0 to array[cnt], then cnt <= cnt + 1.
    - The edge that writes index 2^DEPTH_LOG2-1 moves the state to READY and drops busy.
    - The sweep therefore takes exactly 2^DEPTH_LOG2 cycles after reset deasserts.
    - In CLEAR, readEn0/readEn1/writeEn are ignored: no array write, readData held at 0, addrErr unchanged.
  - READY:
    - Stays in READY until reset.
- Reads (READY only):
  - On a posedge with readEnN = 1, readDataN <= array[idx], or 0 if out of range.
  - Data is valid from that edge onward.
  - readDataN holds its value while readEnN = 0.
  - Ports are fully independent. Both ports may read the same or different idx in the same cycle.
- Write (READY only):
  - On a posedge with writeEn = 1 and writeAddr in range, array[idx] <= writeData.
  - Out-of-range writes are dropped.
- Read/write collision, same cycle, same in-range idx: write-first. The read port returns writeData, not the old contents. This applies to either or both read ports.
- addrErr:
  - Set on the edge of any enabled out-of-range access on any port in READY.
  - Stays set until reset.
- Reset mid-operation:
  - Reset during CLEAR restarts the sweep at index 0.
  - Reset during READY zeroes readData and, if INIT_CLEAR = 1, re-clears the whole array.
- Timing guarantee: no combinational path from any input to any output.

Test Plan:
- INIT_CLEAR=1, DEPTH_LOG2=4: pulse reset one cycle -> busy high exactly 16 cycles, then low; reads of idx 0..15 return 0.
- In READY, write 0x0123456789ABCDEF at addr 5; next cycle readEn1 at addr 5 -> readData1 = 0x0123456789ABCDEF one edge later, held after readEn1 drops.
- Same cycle: writeEn addr 3 data 0xFFFF0000FFFF0000, readEn0 addr 3, readEn1 addr 3 -> both readData = 0xFFFF0000FFFF0000 after that edge.
- DEPTH_LOG2=4: readEn0 at addr 0x10 -> readData0 = 0 and addrErr = 1. A following writeEn at 0x20 leaves idx 0 unchanged; addrErr stays 1.
- During CLEAR, assert writeEn addr 2 data 0xAA -> ignored; idx 2 reads 0 once ready; addrErr = 0.
- Assert reset at sweep cycle 7 -> busy stays high 16 further cycles. Reset in READY after writing idx 9 = 0x55 -> idx 9 reads 0 post-sweep.
